// File: rtl/dsp_chain_ctrl_pkg.sv
// Shared types and widths for the sum-of-products chain job sequencer.
package dsp_chain_ctrl_pkg;

  localparam int N_STAGE  = 4;
  localparam int A_W      = 18;
  localparam int Y_W      = 19;
  localparam int CHAIN_W  = 37;
  localparam int AX_BUS_W = N_STAGE * A_W;
  localparam int Y_BUS_W  = N_STAGE * Y_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Two's-complement add overflows when both operands share a sign the sum lacks.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/dsp_chain_vld_pipe.sv
// 1-bit delay line that marks which chain output cycles carry a real beat.
module dsp_chain_vld_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_vld,
  output logic o_tail
);

  logic [DEPTH-1:0] r_pipe;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_vld;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_tail = r_pipe[DEPTH-1];

endmodule

// File: rtl/dsp_chain_sop_ctrl.sv
// Job sequencer: feeds operand beats into the DSP chain, tracks in-flight
// results and accumulates them into one signed dot-product per job.
module dsp_chain_sop_ctrl
  import dsp_chain_ctrl_pkg::*;
#(
  parameter int CHAIN_LAT = 4,
  parameter int ACC_W     = 48,
  parameter int LEN_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                job_start,
  input  logic [LEN_W-1:0]    job_len,
  output logic                job_busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [AX_BUS_W-1:0] in_ax,
  input  logic [AX_BUS_W-1:0] in_bx,
  input  logic [Y_BUS_W-1:0]  in_ay,
  input  logic [Y_BUS_W-1:0]  in_by,
  output logic [AX_BUS_W-1:0] ch_ax,
  output logic [AX_BUS_W-1:0] ch_bx,
  output logic [Y_BUS_W-1:0]  ch_ay,
  output logic [Y_BUS_W-1:0]  ch_by,
  input  logic [CHAIN_W-1:0]  ch_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_data,
  output logic                out_ovf,
  output state_t              o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and data is stable while valid holds.
  localparam int INFL_W = $clog2(CHAIN_LAT + 3);

  state_t              r_state;
  state_t              w_next;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_beat_cnt;
  logic [LEN_W-1:0]    w_beat_inc;
  logic [INFL_W-1:0]   r_inflight;
  logic [ACC_W-1:0]    r_acc;
  logic                r_ovf;
  logic [AX_BUS_W-1:0] r_ch_ax;
  logic [AX_BUS_W-1:0] r_ch_bx;
  logic [Y_BUS_W-1:0]  r_ch_ay;
  logic [Y_BUS_W-1:0]  r_ch_by;
  logic                r_ch_vld;
  logic                w_tail;
  logic                w_accept;
  logic [ACC_W-1:0]    w_ext;
  logic [ACC_W-1:0]    w_sum;
  logic                w_add_ovf;

  assign w_accept   = in_valid && (r_state == ST_FEED);
  assign w_beat_inc = r_beat_cnt + LEN_W'(1);
  assign w_ext      = ACC_W'($signed(ch_result));
  assign w_sum      = r_acc + w_ext;
  assign w_add_ovf  = add_ovf(r_acc[ACC_W-1], w_ext[ACC_W-1], w_sum[ACC_W-1]);

  // Valid bit travels alongside the registered operands, so the tail lines up
  // with the cycle the chain presents the matching result.
  dsp_chain_vld_pipe #(
    .DEPTH (CHAIN_LAT)
  ) u_vld_pipe (
    .clk    (clk),
    .reset  (reset),
    .i_vld  (r_ch_vld),
    .o_tail (w_tail)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (job_start) begin
          w_next = (job_len == '0) ? ST_DONE : ST_FEED;
        end
      end
      ST_FEED: begin
        if (w_accept && (w_beat_inc == r_len)) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_tail && (r_inflight == INFL_W'(1))) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_inflight <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_ch_ax    <= '0;
      r_ch_bx    <= '0;
      r_ch_ay    <= '0;
      r_ch_by    <= '0;
      r_ch_vld   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_ch_vld <= w_accept;
      // Bubbles put zero operands on the chain so they contribute nothing.
      r_ch_ax  <= w_accept ? in_ax : '0;
      r_ch_bx  <= w_accept ? in_bx : '0;
      r_ch_ay  <= w_accept ? in_ay : '0;
      r_ch_by  <= w_accept ? in_by : '0;

      case ({w_accept, w_tail})
        2'b10:   r_inflight <= r_inflight + INFL_W'(1);
        2'b01:   r_inflight <= r_inflight - INFL_W'(1);
        default: r_inflight <= r_inflight;
      endcase

      if ((r_state == ST_IDLE) && job_start) begin
        r_len      <= job_len;
        r_beat_cnt <= '0;
        r_acc      <= '0;
        r_ovf      <= 1'b0;
      end else begin
        if (w_accept) begin
          r_beat_cnt <= w_beat_inc;
        end
        if (w_tail) begin
          r_acc <= w_sum;
          if (w_add_ovf) begin
            r_ovf <= 1'b1;
          end
        end
      end
    end
  end

  assign ch_ax       = r_ch_ax;
  assign ch_bx       = r_ch_bx;
  assign ch_ay       = r_ch_ay;
  assign ch_by       = r_ch_by;
  assign in_ready    = (r_state == ST_FEED);
  assign job_busy    = (r_state != ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign out_data    = r_acc;
  assign out_ovf     = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dsp_chain_sop_ctrl.sv
// Bench for dsp_chain_sop_ctrl: two instances (48-bit and 38-bit accumulator)
// share stimulus; each is fed by its own behavioural chain model.
module tb_dsp_chain_sop_ctrl;
  import dsp_chain_ctrl_pkg::*;

  localparam int LAT   = 4;
  localparam int LEN_W = 8;
  localparam int EXP_W = 88;

  logic                clk;
  logic                reset;
  logic                job_start;
  logic [LEN_W-1:0]    job_len;
  logic                in_valid;
  logic [AX_BUS_W-1:0] in_ax, in_bx;
  logic [Y_BUS_W-1:0]  in_ay, in_by;
  logic                out_ready;

  logic                d48_job_busy, d48_in_ready, d48_out_valid, d48_out_ovf;
  logic [AX_BUS_W-1:0] d48_ch_ax, d48_ch_bx;
  logic [Y_BUS_W-1:0]  d48_ch_ay, d48_ch_by;
  logic [47:0]         d48_out_data;
  state_t              d48_state;
  logic [CHAIN_W-1:0]  m48 [LAT];

  logic                d38_job_busy, d38_in_ready, d38_out_valid, d38_out_ovf;
  logic [AX_BUS_W-1:0] d38_ch_ax, d38_ch_bx;
  logic [Y_BUS_W-1:0]  d38_ch_ay, d38_ch_by;
  logic [37:0]         d38_out_data;
  state_t              d38_state;
  logic [CHAIN_W-1:0]  m38 [LAT];

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] last_exp;
  longint           acc48, acc38;
  logic             ovf48, ovf38;
  int               cyc;
  int               t_ref;
  int               n_check;
  int               n_pass;
  int               n_fail;

  dsp_chain_sop_ctrl #(.CHAIN_LAT(LAT), .ACC_W(48), .LEN_W(LEN_W)) u_dut48 (
    .clk(clk), .reset(reset), .job_start(job_start), .job_len(job_len),
    .job_busy(d48_job_busy), .in_valid(in_valid), .in_ready(d48_in_ready),
    .in_ax(in_ax), .in_bx(in_bx), .in_ay(in_ay), .in_by(in_by),
    .ch_ax(d48_ch_ax), .ch_bx(d48_ch_bx), .ch_ay(d48_ch_ay), .ch_by(d48_ch_by),
    .ch_result(m48[LAT-1]), .out_valid(d48_out_valid), .out_ready(out_ready),
    .out_data(d48_out_data), .out_ovf(d48_out_ovf), .o_dbg_state(d48_state)
  );

  dsp_chain_sop_ctrl #(.CHAIN_LAT(LAT), .ACC_W(38), .LEN_W(LEN_W)) u_dut38 (
    .clk(clk), .reset(reset), .job_start(job_start), .job_len(job_len),
    .job_busy(d38_job_busy), .in_valid(in_valid), .in_ready(d38_in_ready),
    .in_ax(in_ax), .in_bx(in_bx), .in_ay(in_ay), .in_by(in_by),
    .ch_ax(d38_ch_ax), .ch_bx(d38_ch_bx), .ch_ay(d38_ch_ay), .ch_by(d38_ch_by),
    .ch_result(m38[LAT-1]), .out_valid(d38_out_valid), .out_ready(out_ready),
    .out_data(d38_out_data), .out_ovf(d38_out_ovf), .o_dbg_state(d38_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural chain ----------------
  function automatic longint wrapw(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint sop(input logic [AX_BUS_W-1:0] ax, input logic [Y_BUS_W-1:0] ay,
                                 input logic [AX_BUS_W-1:0] bx, input logic [Y_BUS_W-1:0] by);
    longint s = 0;
    for (int k = 0; k < N_STAGE; k++) begin
      s += longint'($signed(ax[18*k +: 18])) * longint'($signed(ay[19*k +: 19]));
      s += longint'($signed(bx[18*k +: 18])) * longint'($signed(by[19*k +: 19]));
    end
    return wrapw(s, CHAIN_W);
  endfunction

  always @(posedge clk) begin
    m48[0] <= CHAIN_W'(sop(d48_ch_ax, d48_ch_ay, d48_ch_bx, d48_ch_by));
    m38[0] <= CHAIN_W'(sop(d38_ch_ax, d38_ch_ay, d38_ch_bx, d38_ch_by));
    for (int i = 1; i < LAT; i++) begin
      m48[i] <= m48[i-1];
      m38[i] <= m38[i-1];
    end
  end

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [AX_BUS_W-1:0] rep18(input int v);
    logic [17:0] s;
    s = 18'(v);
    return {4{s}};
  endfunction

  function automatic logic [Y_BUS_W-1:0] rep19(input int v);
    logic [18:0] s;
    s = 19'(v);
    return {4{s}};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_add(input longint r);
    longint s;
    longint w;
    s = acc48 + r;
    w = wrapw(s, 48);
    if (w != s) ovf48 = 1'b1;
    acc48 = w;
    s = acc38 + r;
    w = wrapw(s, 38);
    if (w != s) ovf38 = 1'b1;
    acc38 = w;
  endtask

  task automatic start_job(input int len);
    acc48 = 0; acc38 = 0; ovf48 = 1'b0; ovf38 = 1'b0;
    job_start = 1'b1;
    job_len   = LEN_W'(len);
    @(posedge clk);
    #1;
    job_start = 1'b0;
    t_ref = cyc;
  endtask

  task automatic send_beat(input logic [AX_BUS_W-1:0] ax, input logic [Y_BUS_W-1:0] ay,
                           input logic [AX_BUS_W-1:0] bx, input logic [Y_BUS_W-1:0] by);
    int n = 0;
    in_valid = 1'b1;
    in_ax = ax; in_ay = ay; in_bx = bx; in_by = by;
    forever begin
      @(negedge clk);
      if (d48_in_ready) break;
      n++;
      if (n > 20) break;
    end
    if (n > 20) begin
      check("in_ready_timeout", 64'(0), 64'(1));
    end else begin
      @(posedge clk);
      #1;
      t_ref = cyc;
      model_add(sop(ax, ay, bx, by));
    end
    in_valid = 1'b0;
    in_ax = '0; in_ay = '0; in_bx = '0; in_by = '0;
  endtask

  task automatic push_exp();
    exp_q.push_back({ovf48, acc48[47:0], ovf38, acc38[37:0]});
  endtask

  task automatic gap_check(input string tag);
    @(posedge clk);
    #1;
    check(tag, 64'(|{d48_ch_ax, d48_ch_bx, d48_ch_ay, d48_ch_by}), 64'(0));
  endtask

  // Scoreboard: waits for out_valid, checks latency, pops and compares.
  task automatic wait_result(input string tag, input int exp_lat);
    int n = 0;
    forever begin
      @(negedge clk);
      if (d48_out_valid) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      check({tag, "_timeout"}, 64'(0), 64'(1));
    end else begin
      check({tag, "_lat"}, 64'(cyc - t_ref), 64'(exp_lat));
    end
    check({tag, "_v38"}, 64'(d38_out_valid), 64'(1));
    check({tag, "_inrdy"}, 64'(d48_in_ready), 64'(0));
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(0), 64'(1));
    end else begin
      last_exp = exp_q.pop_front();
      check({tag, "_data48"}, 64'(d48_out_data), 64'(last_exp[86:39]));
      check({tag, "_ovf48"},  64'(d48_out_ovf),  64'(last_exp[87]));
      check({tag, "_data38"}, 64'(d38_out_data), 64'(last_exp[37:0]));
      check({tag, "_ovf38"},  64'(d38_out_ovf),  64'(last_exp[38]));
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_idle48"}, 64'(d48_state), 64'(ST_IDLE));
    check({tag, "_idle38"}, 64'(d38_state), 64'(ST_IDLE));
    check({tag, "_busy"}, 64'(d48_job_busy | d48_out_valid), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state48"}, 64'(d48_state), 64'(ST_IDLE));
    check({tag, "_state38"}, 64'(d38_state), 64'(ST_IDLE));
    check({tag, "_ctl"}, 64'({d48_job_busy, d48_in_ready, d48_out_valid, d48_out_ovf,
                              d38_job_busy, d38_in_ready, d38_out_valid, d38_out_ovf}), 64'(0));
    check({tag, "_data"}, 64'(|{d48_out_data, d38_out_data}), 64'(0));
    check({tag, "_ch"}, 64'(|{d48_ch_ax, d48_ch_bx, d48_ch_ay, d48_ch_by,
                              d38_ch_ax, d38_ch_bx, d38_ch_ay, d38_ch_by}), 64'(0));
  endtask

  // ---------------- directed sequence ----------------
  logic [AX_BUS_W-1:0] big_ax, big_bx, one_ax;
  logic [Y_BUS_W-1:0]  big_ay, big_by, one_ay;

  initial begin
    n_check = 0; n_pass = 0; n_fail = 0;
    reset = 1'b0; job_start = 1'b0; job_len = '0; in_valid = 1'b0;
    in_ax = '0; in_bx = '0; in_ay = '0; in_by = '0; out_ready = 1'b0;
    acc48 = 0; acc38 = 0; ovf48 = 1'b0; ovf38 = 1'b0;

    big_ax = {18'd0, 18'd0, 18'd1, 18'h20000};
    big_bx = {18'd0, 18'd0, 18'd0, 18'h20000};
    big_ay = {19'd0, 19'd0, 19'h7FFFF, 19'h40000};
    big_by = {19'd0, 19'd0, 19'd0, 19'h40000};
    one_ax = {54'd0, 18'd1};
    one_ay = {57'd0, 19'd1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single beat: 4 stages of 1*2 + 3*4 = 56
    start_job(1);
    check("t1_in_ready", 64'(d48_in_ready), 64'(1));
    send_beat(rep18(1), rep19(2), rep18(3), rep19(4));
    push_exp();
    wait_result("t1", LAT + 1);
    handshake("t1");

    // Gapped stream: 56, -10, 100 with two idle cycles between beats
    start_job(3);
    send_beat(rep18(1), rep19(2), rep18(3), rep19(4));
    gap_check("t2_gap1a");
    gap_check("t2_gap1b");
    send_beat(one_ax, {57'd0, 19'(-10)}, '0, '0);
    gap_check("t2_gap2a");
    gap_check("t2_gap2b");
    send_beat(rep18(5), rep19(5), '0, '0);
    push_exp();
    wait_result("t2", LAT + 1);
    handshake("t2");

    // Backpressure: hold DONE, pulse job_start, data must not move
    start_job(1);
    send_beat(rep18(2), rep19(3), rep18(-1), rep19(5));
    push_exp();
    wait_result("t4", LAT + 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      job_start = (i == 1);
      job_len   = LEN_W'(5);
      @(negedge clk);
      check("t4_hold_data", 64'(d48_out_data), 64'(last_exp[86:39]));
      check("t4_hold_state", 64'(d48_state), 64'(ST_DONE));
    end
    job_start = 1'b0;
    handshake("t4");
    @(negedge clk);
    check("t4_stay_idle", 64'(d48_state), 64'(ST_IDLE));

    // Overflow: three beats of 2^36-1 then a beat of 1
    start_job(4);
    send_beat(big_ax, big_ay, big_bx, big_by);
    send_beat(big_ax, big_ay, big_bx, big_by);
    send_beat(big_ax, big_ay, big_bx, big_by);
    send_beat(one_ax, one_ay, '0, '0);
    push_exp();
    wait_result("t5", LAT + 1);
    handshake("t5");

    // Zero-length job right after the overflow job: result 0, ovf cleared
    start_job(0);
    check("t3_no_in_ready", 64'(d48_in_ready), 64'(0));
    push_exp();
    wait_result("t3", 0);
    handshake("t3");

    // Reset in DRAIN, then a fresh job sees only its own beat
    start_job(2);
    send_beat(rep18(7), rep19(7), rep18(7), rep19(7));
    send_beat(rep18(7), rep19(7), rep18(7), rep19(7));
    check("t6_drain", 64'(d48_state), 64'(ST_DRAIN));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_all_zero("t6_rst");
    start_job(1);
    send_beat(rep18(1), rep19(2), rep18(3), rep19(4));
    push_exp();
    wait_result("t6", LAT + 1);
    handshake("t6");
    check("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule

// File: doc/dsp_chain_sop_ctrl.md
# dsp_chain_sop_ctrl

Job sequencer for a 4-stage cascaded integer sum-of-products DSP chain. Each stage computes ax·ay + bx·by plus its chain input. The block accepts a job (beat count), streams operand beats into the chain under valid/ready flow control, and tracks in-flight beats through the chain latency. It accumulates each chain result into a wide signed accumulator and returns one dot-product result per job over a valid/ready output. It sits between the operand-fetch logic and the DSP chain instance.

## Interface
- CHAIN_LAT, 4, cycles from operands presented on ch_* to the matching value on ch_result
- ACC_W, 48, accumulator/result width (≥ 37)
- LEN_W, 8, job length counter width
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- job_start  in  1  start pulse; sampled only in IDLE
- job_len  in  LEN_W  beats in job; latched with job_start
- job_busy  out  1  high in any state except IDLE
- in_valid  in  1  operand beat valid
- in_ready  out  1  high only in FEED
- in_ax, in_bx  in  72  4×18 signed, stage k at [18k+17:18k]
- in_ay, in_by  in  76  4×19 signed, stage k at [19k+18:19k]
- ch_ax, ch_bx  out  72  registered operands to chain
- ch_ay, ch_by  out  76  registered operands to chain
- ch_result  in  37  signed chain output (sum of 8 products)
- out_valid  out  1  result available
- out_ready  in  1  result consumed
- out_data  out  ACC_W  signed accumulated result
- out_ovf  out  1  sticky signed overflow during job

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- IDLE
  - job_start=1 latches job_len, clears acc/ovf/beat count.
  - Next state is FEED, or DONE directly if job_len=0, with out_data=0.
  - job_start is ignored in every other state.
- FEED
  - in_valid&in_ready accepts a beat: operands are registered onto ch_*, a 1 enters the valid delay line, and the beat count increments.
  - Cycles with no accepted beat drive ch_* to all-zero, so bubbles add 0, and push 0 into the delay line.
  - The accept of beat job_len moves FEED to DRAIN.
- DRAIN
  - in_ready=0 and ch_* are zero.
  - Leaves for DONE on the edge that accumulates the last in-flight result.
  - An in-flight counter (increment on push, decrement on tail) gates the exit.
- Accumulate in any state when the delay-line tail is 1: acc <= acc + sign_extend(ch_result).
  - Wrap modulo 2^ACC_W.
  - out_ovf is set if the signed add overflows and stays set until the next job_start.
- DONE
  - out_valid=1, with out_data and out_ovf held stable until out_ready.
  - out_valid&out_ready moves DONE to IDLE.
- Reset values (reset=0 at a clock edge):
  - state IDLE.
  - All ch_*, out_data, acc, counters and the delay line are 0.
  - out_valid, out_ovf, in_ready, job_busy are 0.
- Reset mid-job aborts cleanly. Chain results still in flight are ignored because the delay line is cleared.

## Timing
- Beat accepted at edge t is on ch_* during cycle t+1. Its result is on ch_result during cycle t+1+CHAIN_LAT and is added at the end of that cycle.
- Last beat accepted at edge t: out_valid first high in cycle t+2+CHAIN_LAT.
- job_start at edge t: in_ready high from cycle t+1. For job_len=0, out_valid is high from cycle t+1.
- Full throughput: one beat per cycle while in_valid stays high.
- in_ready drops combinationally-free, as a registered state decode, in the cycle after the last beat accept.
- out_valid held with out_ready=0 for any number of cycles: no state change, and job_start is ignored.

## Structure
- Shared package dsp_chain_ctrl_pkg holds:
  - state enum.
  - N_STAGE=4, A_W=18, Y_W=19, CHAIN_W=37.
  - packed-bus width constants (72/76).
- Sub-module dsp_chain_vld_pipe: CHAIN_LAT-deep 1-bit delay line with synchronous active-low clear.
- FSM, counters, operand registers and accumulator live in the top.

## Test plan
- Bench drives ch_result from a behavioural chain model with CHAIN_LAT delay.
- Single beat: job_len=1, all ax=1, ay=2, bx=3, by=4 → out_data=56 in cycle t+2+CHAIN_LAT, out_ovf=0.
- Gapped stream: job_len=3, beats giving 56, −10, 100 with in_valid low 2 cycles between beats → out_data=146; zero operands observed on ch_* during gaps.
- job_len=0 → out_valid the cycle after job_start, out_data=0, no in_ready.
- Backpressure: out_ready low 5 cycles in DONE → out_data stable; job_start pulsed then is ignored; IDLE after the handshake.
- Overflow with ACC_W=38:
  - Beats 1–3 each produce 2^36−1 (4-bit-length job, job_len=4).
  - The 2nd add yields 2^37−2, in range.
  - The 3rd add exceeds 2^37−1 → out_ovf=1.
  - out_data equals the wrapped 38-bit value 3·(2^36−1) − 2^38 after beat 3, plus beat 4 (=1): 3·2^36 − 2 − 2^38.
- Reset mid-DRAIN: reset=0 for one edge → all outputs 0, state IDLE. A new job_len=1 job then returns only its own result (56).
